// File: rtl/com_sync_fifo_mode_if.sv
// Producer/consumer bundle of com_sync_fifo_mode: write side, read side,
// level/threshold flags and sticky error flags.
interface com_sync_fifo_mode_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          clear;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_full;
  logic          wr_afull;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          rd_aempty;
  logic [CW-1:0] water_level;
  logic          overflow;
  logic          underflow;

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output wr_full, wr_afull, rd_data, rd_empty, rd_aempty,
           water_level, overflow, underflow
  );

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty,
           water_level, overflow, underflow
  );
endinterface

// File: rtl/com_sync_fifo_mode.sv
// Synchronous FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, programmable almost-full/almost-empty and sticky error flags.
module com_sync_fifo_mode #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic clk,
  input  logic rst,
  com_sync_fifo_mode_if.slave fifo
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_TH);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [PW-1:0] C_LAST   = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("com_sync_fifo_mode: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("com_sync_fifo_mode: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("com_sync_fifo_mode: AEMPTY_TH must be in 0..DEPTH-1");
  end

  // Pointer advance with wrap at the last slot, since DEPTH need not be 2^n.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] ptr);
    f_inc = (ptr == C_LAST) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_level;
  logic [CW-1:0] w_level_nxt;
  logic [DW-1:0] r_rd_data;
  logic          r_full;
  logic          r_afull;
  logic          r_empty;
  logic          r_aempty;
  logic          r_ovf;
  logic          r_udf;
  logic          w_wr_acc;
  logic          w_rd_acc;

  assign w_wr_acc = fifo.wr_en && !r_full;
  assign w_rd_acc = fifo.rd_en && !r_empty;

  // Next occupancy: a simultaneous accepted read and write cancel out.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + C_ONE;
      2'b01:   w_level_nxt = r_level - C_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && !fifo.clear && w_wr_acc) begin
      r_mem[r_wr_ptr] <= fifo.wr_data;
    end
  end

  // Pointers, level, flags and sticky errors; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || fifo.clear) begin
      r_wr_ptr  <= {PW{1'b0}};
      r_rd_ptr  <= {PW{1'b0}};
      r_level   <= {CW{1'b0}};
      r_rd_data <= {DW{1'b0}};
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_empty   <= 1'b1;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
        if (FWFT == 0) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == C_DEPTH);
      r_afull  <= (w_level_nxt >= C_AFULL);
      r_empty  <= (w_level_nxt == {CW{1'b0}});
      r_aempty <= (w_level_nxt <= C_AEMPTY);
      r_ovf    <= r_ovf | (fifo.wr_en & r_full);
      r_udf    <= r_udf | (fifo.rd_en & r_empty);
    end
  end

  // FWFT shows the head slot directly; standard mode shows the popped word.
  assign fifo.rd_data     = (FWFT != 0) ? r_mem[r_rd_ptr] : r_rd_data;
  assign fifo.wr_full     = r_full;
  assign fifo.wr_afull    = r_afull;
  assign fifo.rd_empty    = r_empty;
  assign fifo.rd_aempty   = r_aempty;
  assign fifo.water_level = r_level;
  assign fifo.overflow    = r_ovf;
  assign fifo.underflow   = r_udf;
endmodule

// File: tb/tb_com_sync_fifo_mode.sv
// Scoreboard bench: a standard-mode and an FWFT instance (DEPTH=5) share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_com_sync_fifo_mode;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AFT   = 4;
  localparam int AET   = 1;

  typedef struct {
    int          lvl;
    bit          full, afull, empty, aempty, ovf, udf;
    logic [7:0]  d0;
    logic [7:0]  d1;
    bit          d1_v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  com_sync_fifo_mode_if #(.DW(DW), .DEPTH(DEPTH)) if0 ();
  com_sync_fifo_mode_if #(.DW(DW), .DEPTH(DEPTH)) if1 ();

  com_sync_fifo_mode #(.DW(DW), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(AFT), .AEMPTY_TH(AET))
    u_std (.clk(clk), .rst(rst), .fifo(if0));
  com_sync_fifo_mode #(.DW(DW), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(AFT), .AEMPTY_TH(AET))
    u_fwft (.clk(clk), .rst(rst), .fifo(if1));

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_d0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic step(input bit r, input bit c, input bit we, input logic [7:0] wd, input bit re);
    exp_t e;
    bit wa, ra;
    @(negedge clk);
    rst = r;
    if0.clear = c;  if1.clear = c;
    if0.wr_en = we; if1.wr_en = we;
    if0.wr_data = wd; if1.wr_data = wd;
    if0.rd_en = re; if1.rd_en = re;
    if (r || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_d0  = 8'h00;
    end else begin
      wa = we && (mq.size() < DEPTH);
      ra = re && (mq.size() > 0);
      if (we && !wa) m_ovf = 1'b1;
      if (re && !ra) m_udf = 1'b1;
      if (ra) m_d0 = mq.pop_front();
      if (wa) mq.push_back(wd);
    end
    e.lvl    = mq.size();
    e.full   = (mq.size() == DEPTH);
    e.afull  = (mq.size() >= AFT);
    e.empty  = (mq.size() == 0);
    e.aempty = (mq.size() <= AET);
    e.ovf    = m_ovf;
    e.udf    = m_udf;
    e.d0     = m_d0;
    e.d1_v   = (mq.size() > 0);
    e.d1     = e.d1_v ? mq[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare both instances against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("std.level",     int'(if0.water_level), e.lvl);
        chk("std.full",      int'(if0.wr_full),     int'(e.full));
        chk("std.afull",     int'(if0.wr_afull),    int'(e.afull));
        chk("std.empty",     int'(if0.rd_empty),    int'(e.empty));
        chk("std.aempty",    int'(if0.rd_aempty),   int'(e.aempty));
        chk("std.overflow",  int'(if0.overflow),    int'(e.ovf));
        chk("std.underflow", int'(if0.underflow),   int'(e.udf));
        chk("std.rd_data",   int'(if0.rd_data),     int'(e.d0));
        chk("fwft.level",    int'(if1.water_level), e.lvl);
        chk("fwft.full",     int'(if1.wr_full),     int'(e.full));
        chk("fwft.afull",    int'(if1.wr_afull),    int'(e.afull));
        chk("fwft.empty",    int'(if1.rd_empty),    int'(e.empty));
        chk("fwft.aempty",   int'(if1.rd_aempty),   int'(e.aempty));
        chk("fwft.overflow", int'(if1.overflow),    int'(e.ovf));
        chk("fwft.underflow",int'(if1.underflow),   int'(e.udf));
        if (e.d1_v) chk("fwft.rd_data", int'(if1.rd_data), int'(e.d1));
      end
    end
  end

  initial begin
    logic [7:0] cnt;
    rst = 1'b1;
    if0.clear = 1'b0; if1.clear = 1'b0;
    if0.wr_en = 1'b0; if1.wr_en = 1'b0;
    if0.rd_en = 1'b0; if1.rd_en = 1'b0;
    if0.wr_data = 8'h00; if1.wr_data = 8'h00;
    m_ovf = 1'b0; m_udf = 1'b0; m_d0 = 8'h00;

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // fill 0x11..0x55, then drain
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 8'(i * 17), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // pointer wrap, then overflow on a sixth write
    cnt = 8'h60;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b0, 1'b1, cnt, 1'b0);
        cnt = cnt + 8'h01;
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // fall-through of a single word
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // simultaneous read/write at level 1 and at full
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // underflow, then clear with both requests high
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hE2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // reset mid-burst with clear and write high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hBB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55),
           8'($urandom), ($urandom_range(0, 99) < 50));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/com_sync_fifo_mode.md
Name: com_sync_fifo_mode

Overview:
Parametrised synchronous FIFO; successor to the basic register FIFO used across the com library.
- Adds non-power-of-2 depth, selectable read mode (standard / first-word-fall-through) and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags.
- Sits between single-clock producer/consumer blocks (cpu/com datapaths) as the default elastic buffer.

Parameters:
DW, 8, data width in bits (>=1)
DEPTH, 4, number of entries (>=2, any integer, not restricted to power of 2)
FWFT, 0, read mode: 0 = standard (data 1 cycle after rd_en), 1 = first-word-fall-through
AFULL_TH, DEPTH-1, wr_afull asserts when level >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 1, rd_aempty asserts when level <= AEMPTY_TH (0..DEPTH-1)
CW, $clog2(DEPTH+1), derived level width, not overridden

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
clear  input  1  synchronous flush, active-high
wr_en  input  1  write request
wr_data  input  DW  write data
wr_full  output  1  level == DEPTH
wr_afull  output  1  level >= AFULL_TH
rd_en  input  1  read request (FWFT=1: pop/acknowledge of shown word)
rd_data  output  DW  read data
rd_empty  output  1  no word readable
rd_aempty  output  1  level <= AEMPTY_TH
water_level  output  CW  current entry count
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset values: wr_full=0, wr_afull=0, rd_empty=1, rd_aempty=1, water_level=0, rd_data=0, overflow=0, underflow=0; pointers=0.
- Priority: rst > clear > rd/wr.
- clear: same effect as rst on pointers, level, flags, sticky errors and rd_data. Any wr_en/rd_en in the clear cycle is ignored and sets no error flag.
- Write accepted iff wr_en && !wr_full. Entry stored at wr_ptr; wr_ptr increments.
- Read accepted iff rd_en && !rd_empty; rd_ptr increments.
- Pointers wrap DEPTH-1 -> 0.
- wr_full uses the registered level only: a write while full is rejected even if a read is accepted in the same cycle.
- Rejected write: data dropped, overflow set next cycle, held until rst/clear.
- Rejected read: state unchanged, underflow set next cycle, held until rst/clear.
- Level update per cycle: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
- All flags and water_level are registered and reflect the level after the clock edge.
- Simultaneous accepted read and write at level 1: legal, level stays 1, the new word follows the popped word.
- FWFT=0:
  - rd_data is registered; it takes mem[rd_ptr] on the edge of an accepted read, so it is valid in the cycle after rd_en.
  - rd_data holds its value otherwise, including on a rejected read.
  - rd_empty = (level==0).
- FWFT=1:
  - rd_data continuously presents the head entry mem[rd_ptr] whenever !rd_empty. It is don't-care while empty; the bench masks it.
  - rd_en pops the head; the next entry appears in the same cycle the pop is registered.
  - Write into empty FIFO: rd_empty deasserts 1 cycle after the write edge, and rd_data equals the written word in that cycle.
  - rd_empty = (level==0).
- Memory: register array DW x DEPTH, not reset (contents don't-care after rst/clear).
- Elaboration check with $error on illegal parameters: DEPTH<2, AFULL_TH outside 1..DEPTH, AEMPTY_TH outside 0..DEPTH-1.

Test Plan:
1. DW=8, DEPTH=5, FWFT=0: write 0x11..0x55 over 5 cycles -> wr_full=1 and water_level=5 after 5th edge; wr_afull=1 from level 4. Then read 5 -> rd_data 0x11..0x55, each 1 cycle after rd_en; rd_empty=1 after last.
2. DEPTH=5 wrap: loop 3x (write 3, read 3), 9 words total -> pointers wrap past 4 and data order is preserved. Then a 6th write while full -> write dropped, overflow=1 sticky, level stays 5.
3. FWFT=1, empty FIFO, write 0xA5 -> next cycle rd_empty=0 and rd_data=0xA5 with no rd_en. rd_en for one cycle -> rd_empty=1 next cycle, level=0.
4. Level 1: assert wr_en(0x3C) and rd_en together -> level stays 1, popped word is the old head, and 0x3C is the next head. At full with both asserted -> read accepted, write rejected, overflow=1, level=4.
5. rd_en on empty -> underflow=1 and rd_data unchanged (FWFT=0). Then clear with wr_en and rd_en high -> next cycle level=0, overflow=underflow=0, rd_empty=1, no write stored.
6. rst asserted mid-burst at level 3 with clear and wr_en high -> all outputs at reset values next cycle. A write after rst deasserts stores normally at slot 0.
